// File: rtl/mil_rx_buffer_pkg.sv
// Shared 1553 word types plus the receive-buffer sizing constant.
// Word type encoding follows the receiver's decode order.
package milStd1553;

    typedef enum logic [1:0] {
        WCOMMAND = 2'd0,
        WSTATUS  = 2'd1,
        WDATA    = 2'd2,
        WERROR   = 2'd3
    } word_type_t;

    typedef struct packed {
        word_type_t  wtype;
        logic [15:0] word;
    } mil_word_t;

endpackage

package mil_rx_buffer_pkg;

    localparam int MIL_RX_BUFFER_DEPTH = 32;

endpackage

// File: rtl/mil_fifo_mem.sv
// DEPTH x 18 word storage: one write port, one registered read port.
// Read data appears the cycle after rd_en; no backpressure, caller owns addressing.
module mil_fifo_mem
    import milStd1553::*;
#(
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  mil_word_t       wr_dat,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output mil_word_t       rd_dat
);

    mil_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mil_rx_buffer.sv
// FWFT receive word FIFO behind the 1553 receiver; head valid one cycle after push/pop edge.
// Push while full (no pop) is dropped and flagged; pop while empty is ignored and flagged.
module mil_rx_buffer
    import milStd1553::*;
    import mil_rx_buffer_pkg::*;
#(
    parameter int  DEPTH = MIL_RX_BUFFER_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            pushRequest,
    input  logic [1:0]      pushType,
    input  logic [15:0]     pushWord,
    input  logic            popRequest,
    output logic [1:0]      headType,
    output logic [15:0]     headWord,
    output logic            headValid,
    output logic [AW:0]     count,
    output logic            full,
    output logic            overflow,
    output logic            underflow,
    input  logic            clearErrors,
    output logic [AW:0]     cmdCount
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_nxt;
    logic [AW:0]   count_q;
    logic [AW:0]   cmd_q;
    logic          nonempty;
    logic          push_acc;
    logic          pop_acc;
    logic          push_is_cmd;
    logic          pop_is_cmd;
    logic          ovf_evt;
    logic          udf_evt;
    logic          ovf_q;
    logic          udf_q;
    logic          rd_en;
    logic          wr_en;
    logic          load_byp;
    logic          head_sel_q;
    mil_word_t     push_w;
    mil_word_t     byp_q;
    mil_word_t     rd_dat;
    mil_word_t     head_w;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == DEPTH_CNT);
    assign rptr_nxt = rptr + AW'(1);

    assign push_w.wtype = word_type_t'(pushType);
    assign push_w.word  = pushWord;

    assign pop_acc  = popRequest & nonempty;
    assign push_acc = pushRequest & enable & (~full | pop_acc);
    assign ovf_evt  = pushRequest & enable & full & ~pop_acc;
    assign udf_evt  = popRequest & ~nonempty;

    assign push_is_cmd = push_acc & (push_w.wtype == WCOMMAND);
    assign pop_is_cmd  = pop_acc & (head_w.wtype == WCOMMAND);

    // The head comes from a bypass register when the incoming word must become
    // the head immediately (empty buffer, or popping the last word while pushing);
    // otherwise it comes from the registered RAM read issued on the pop.
    assign load_byp = push_acc & (~nonempty | (pop_acc & (count_q == ONE_CNT)));
    assign rd_en    = ~rst & pop_acc & (count_q > ONE_CNT);
    assign wr_en    = ~rst & push_acc;

    mil_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_dat  (push_w),
        .rd_en   (rd_en),
        .rd_addr (rptr_nxt),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            cmd_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            head_sel_q <= 1'b1;
            byp_q      <= '{wtype: WDATA, word: 16'h0000};
        end else begin
            if (push_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_acc) begin
                rptr <= rptr_nxt;
            end
            count_q <= count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
            cmd_q   <= cmd_q + (AW+1)'(push_is_cmd) - (AW+1)'(pop_is_cmd);

            if (load_byp) begin
                byp_q      <= push_w;
                head_sel_q <= 1'b1;
            end else if (rd_en) begin
                head_sel_q <= 1'b0;
            end

            // A same-cycle error event beats clearErrors.
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (clearErrors) begin
                ovf_q <= 1'b0;
            end
            if (udf_evt) begin
                udf_q <= 1'b1;
            end else if (clearErrors) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign head_w    = head_sel_q ? byp_q : rd_dat;
    assign headType  = head_w.wtype;
    assign headWord  = head_w.word;
    assign headValid = nonempty;
    assign count     = count_q;
    assign cmdCount  = cmd_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_mil_rx_buffer.sv
// Self-checking bench for mil_rx_buffer: directed scenarios then random traffic
// against a queue-based reference model.
module tb_mil_rx_buffer;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        pushRequest = 1'b0;
    logic [1:0]  pushType = 2'd0;
    logic [15:0] pushWord = 16'h0;
    logic        popRequest = 1'b0;
    logic        clearErrors = 1'b0;
    logic [1:0]  headType;
    logic [15:0] headWord;
    logic        headValid;
    logic [5:0]  count;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic [5:0]  cmdCount;

    always #5 clk = ~clk;

    mil_rx_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pushRequest (pushRequest),
        .pushType    (pushType),
        .pushWord    (pushWord),
        .popRequest  (popRequest),
        .headType    (headType),
        .headWord    (headWord),
        .headValid   (headValid),
        .count       (count),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .clearErrors (clearErrors),
        .cmdCount    (cmdCount)
    );

    // Reference model: the stored words in arrival order, plus sticky flags.
    logic [17:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic        m_fresh = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic pr, input logic [1:0] pt, input logic [15:0] pw,
                              input logic pp, input logic en, input logic clr, input logic r);
        bit pop_ok, push_ok, ovf_ev, udf_ev;
        if (r) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            pop_ok  = pp && (q.size() > 0);
            push_ok = pr && en && ((q.size() < DEPTH) || pop_ok);
            ovf_ev  = pr && en && (q.size() == DEPTH) && !pop_ok;
            udf_ev  = pp && (q.size() == 0);
            if (pop_ok) void'(q.pop_front());
            if (push_ok) begin
                q.push_back({pt, pw});
                m_fresh = 1'b0;
            end
            if (ovf_ev) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (udf_ev) m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
        end
    endtask

    task automatic check_outputs();
        int ncmd;
        ncmd = 0;
        foreach (q[i]) if (q[i][17:16] == 2'd0) ncmd++;
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("headValid", 32'(headValid), 32'(q.size() != 0));
        check_eq("cmdCount", 32'(cmdCount), 32'(ncmd));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_udf));
        if (q.size() != 0) begin
            check_eq("headType", 32'(headType), 32'(q[0][17:16]));
            check_eq("headWord", 32'(headWord), 32'(q[0][15:0]));
        end else if (m_fresh) begin
            check_eq("rstHeadType", 32'(headType), 32'd2);
            check_eq("rstHeadWord", 32'(headWord), 32'h0);
        end
    endtask

    task automatic cycle(input logic pr, input logic [1:0] pt, input logic [15:0] pw,
                         input logic pp, input logic en, input logic clr, input logic r);
        pushRequest = pr;
        pushType    = pt;
        pushWord    = pw;
        popRequest  = pp;
        enable      = en;
        clearErrors = clr;
        rst         = r;
        @(posedge clk);
        model_step(pr, pt, pw, pp, en, clr, r);
        @(negedge clk);
        pushRequest = 1'b0;
        popRequest  = 1'b0;
        clearErrors = 1'b0;
        rst         = 1'b0;
        check_outputs();
    endtask

    task automatic push(input logic [1:0] t, input logic [15:0] w);
        cycle(1'b1, t, w, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // 1: basic FWFT with command accounting
        push(2'd0, 16'hEFAB);
        push(2'd2, 16'h02A1);
        pop();
        pop();

        // 2: fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) push(2'd2, 16'(i));
        push(2'd2, 16'hDEAD);
        for (int i = 0; i < DEPTH; i++) pop();
        cycle(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // 3: full with simultaneous push and pop across pointer wrap
        for (int i = 0; i < DEPTH; i++) push(2'(i % 4), 16'(16'h0100 + i));
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'(i % 3), 16'(16'h0200 + i), 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop();

        // 4: push and pop on empty buffer, then clear
        cycle(1'b1, 2'd2, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        pop();

        // 5: pushes ignored while disabled
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 16'(16'h0500 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        push(2'd1, 16'h0555);

        // 6: reset with a push in flight
        push(2'd0, 16'h0601);
        push(2'd0, 16'h0602);
        cycle(1'b1, 2'd0, 16'h0603, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic, phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int bias;
            logic pr, pp, en, clr, r;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            pr  = ($urandom_range(0, 99) < bias);
            pp  = ($urandom_range(0, 99) < (100 - bias));
            en  = ($urandom_range(0, 99) < 90);
            clr = ($urandom_range(0, 99) < 5);
            r   = ($urandom_range(0, 999) < 3);
            cycle(pr, 2'($urandom_range(0, 3)), 16'($urandom), pp, en, clr, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mil_rx_buffer.md
Name: mil_rx_buffer

Overview:
- Receive-side word buffer directly downstream of the MIL-STD-1553 receiver.
- Captures every word the receiver pushes (word type plus 16-bit payload) into a circular FIFO.
- Presents the oldest word to the SPI-side consumer with first-word-fall-through semantics.
- Tracks fill level, overflow and underflow so the host can detect lost or bogus traffic.

Parameters:
- DEPTH, 32, number of stored words; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  when low, incoming pushes are ignored
- pushRequest  input  1  single-cycle strobe from receiver: word valid
- pushType  input  2  word type, milStd1553 word-type enum (WCOMMAND/WSTATUS/WDATA/WERROR)
- pushWord  input  16  received word payload
- popRequest  input  1  single-cycle strobe from consumer: discard head word
- headType  output  2  type of oldest stored word
- headWord  output  16  payload of oldest stored word
- headValid  output  1  buffer non-empty; head outputs meaningful
- count  output  AW+1  number of stored words, 0..DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a push arrived while full
- underflow  output  1  sticky: a pop arrived while empty
- clearErrors  input  1  single-cycle strobe, clears overflow/underflow
- cmdCount  output  AW+1  number of stored WCOMMAND words, used as the message-boundary hint

Behaviour:
- Reset (rst=1 at posedge clk): pointers=0, count=0, cmdCount=0, headValid=0, full=0, overflow=0, underflow=0, headType=WDATA, headWord=16'h0000. Storage contents are don't-care.
- Reset mid-operation discards all stored words immediately. Any push or pop in the reset cycle is ignored.
- Push accepted on a cycle with pushRequest & enable & (!full | pop accepted in the same cycle):
  - word written at wptr;
  - wptr wraps modulo DEPTH.
- Pop accepted on a cycle with popRequest & headValid: rptr increments and wraps modulo DEPTH.
- Latency:
  - A word pushed into an empty buffer appears on headType/headWord with headValid=1 on the cycle after the push edge.
  - After a pop, the next word appears on the cycle after the pop edge.
- Simultaneous push and pop:
  - Non-empty, not full: both accepted; count unchanged.
  - Full: both accepted; count stays DEPTH; no overflow.
  - Empty: push accepted, pop rejected, underflow set; count becomes 1.
- Push while full with no pop: word dropped, overflow <= 1, contents unchanged.
- Push while enable=0: ignored silently; no flag set.
- Pop while empty: ignored, underflow <= 1.
- clearErrors:
  - Clears both sticky flags on the next edge.
  - If an error event occurs in the same cycle, setting wins and the flag stays 1.
- cmdCount:
  - +1 on an accepted push of WCOMMAND.
  - −1 on an accepted pop whose head is WCOMMAND.
  - Both in the same cycle: unchanged.
- count and cmdCount are registered. full is derived from registered count. No combinational path from pushRequest to any output.
- Storage is a register array or inferred simple dual-port RAM. The read path must meet FWFT timing: use a registered output stage refreshed on write-to-empty and on pop.
- pushType values outside the enum are stored unchanged.

Decomposition:
- The milStd1553 package already holds the word-type enum and the packed word struct (type+word); reuse both, nothing new added there.
- Add to the package: constant MIL_RX_BUFFER_DEPTH = 32.
- One natural sub-module: mil_fifo_mem (DEPTH×18 storage, one write port, one registered read port). Pointer/flag logic stays in mil_rx_buffer.

Test Plan:
1. Reset, push (WCOMMAND,16'hEFAB) then (WDATA,16'h02A1) →
   - cycle after first push: headValid=1, head=WCOMMAND/EFAB, count=1, cmdCount=1;
   - after second: count=2;
   - pop → head=WDATA/02A1, count=1, cmdCount=0;
   - pop → headValid=0, count=0.
2. Push 32 words 16'h0000..16'h001F →
   - full=1, count=32;
   - 33rd push 16'hDEAD → overflow=1, count=32;
   - pop all 32 → words 0000..001F in order, DEAD never appears.
3. Fill to 32, then push+pop in the same cycle 40 times with incrementing payloads →
   - count stays 32, overflow stays 0;
   - drained order continuous across pointer wrap.
4. Empty buffer, simultaneous push 16'h1234 and pop → count=1, head=1234, underflow=1; clearErrors → underflow=0 next cycle.
5. enable=0, push 5 words → count=0, no flags; enable=1, push 1 → count=1.
6. Fill with 3 words, assert rst for one cycle together with a push → all outputs at reset values, count=0 on the following cycle.
